// File: rtl/regfile_wbq_pkg.sv
// rtl/regfile_wbq_pkg.sv - shared types and widths for the regfile write-back queue
// Contents: RF_ADDR_W, RF_DATA_W, wbq_entry_t {addr, data}.
package regfile_wbq_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_wbq_match.sv
// rtl/regfile_wbq_match.sv - youngest-match lookup over the pending write entries
// Ports: entries (storage array), rd_ptr (oldest entry), count (occupancy),
//        lk_addr (lookup address) -> lk_hit, lk_data (newest pending data, else 0).
module regfile_wbq_match
    import regfile_wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wbq_entry_t [DEPTH-1:0]      entries,
    input  logic [$clog2(DEPTH)-1:0]    rd_ptr,
    input  logic [$clog2(DEPTH):0]      count,
    input  logic [RF_ADDR_W-1:0]        lk_addr,
    output logic                        lk_hit,
    output logic [RF_DATA_W-1:0]        lk_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk entries oldest to youngest starting at rd_ptr; a later match
    // overwrites an earlier one, so the youngest matching entry wins.
    // Validity is derived from age < count, so reset of count alone
    // invalidates everything.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (lk_addr != '0) && (entries[idx].addr == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back FIFO in front of a 32x32 regfile write port
// Config macro: REGFILE_WBQ_FWD_EN enables the two lookup (forwarding) ports;
//   when undefined lk_hit*/lk_data* are tied to 0.
// Ports: clk, reset (async, active-high);
//        enq_val/enq_rdy/enq_waddr/enq_wdata - write request in;
//        drain_en -> wen/waddr/wdata - regfile write port out (head entry);
//        lk_addrK -> lk_hitK/lk_dataK - lookup of pending writes, K = 0,1;
//        count - occupancy.
module regfile_wb_queue
    import regfile_wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_val,
    output logic                      enq_rdy,
    input  logic [4:0]                enq_waddr,
    input  logic [31:0]               enq_wdata,
    input  logic                      drain_en,
    output logic                      wen,
    output logic [4:0]                waddr,
    output logic [31:0]               wdata,
    input  logic [4:0]                lk_addr0,
    output logic                      lk_hit0,
    output logic [31:0]               lk_data0,
    input  logic [4:0]                lk_addr1,
    output logic                      lk_hit1,
    output logic [31:0]               lk_data1,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbq_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push;
    wbq_entry_t             head;

    assign enq_rdy = (count_q < CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = entries_q[rd_ptr_q];
    assign wen     = drain_en && (count_q != '0);
    assign waddr   = wen ? head.addr : '0;
    assign wdata   = wen ? head.data : '0;

    // Writes to r0 are handshaken but never stored.
    assign push = enq_val && enq_rdy && (enq_waddr != '0);

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            entries_d[wr_ptr_q] = '{addr: enq_waddr, data: enq_wdata};
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (wen) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, wen})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

`ifdef REGFILE_WBQ_FWD_EN
    regfile_wbq_match #(.DEPTH(DEPTH)) u_match0 (
        .entries (entries_q),
        .rd_ptr  (rd_ptr_q),
        .count   (count_q),
        .lk_addr (lk_addr0),
        .lk_hit  (lk_hit0),
        .lk_data (lk_data0)
    );

    regfile_wbq_match #(.DEPTH(DEPTH)) u_match1 (
        .entries (entries_q),
        .rd_ptr  (rd_ptr_q),
        .count   (count_q),
        .lk_addr (lk_addr1),
        .lk_hit  (lk_hit1),
        .lk_data (lk_data1)
    );
`else
    logic unused_lk_addr;

    assign unused_lk_addr = ^{lk_addr0, lk_addr1};
    assign lk_hit0        = 1'b0;
    assign lk_data0       = '0;
    assign lk_hit1        = 1'b0;
    assign lk_data1       = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of pending write entries (power of two, 2..16).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named clk and reset.
REQ-003 The port list SHALL be, in order:
- clk  input  1  clock
- reset  input  1  async active-high reset
- enq_val  input  1  write request valid
- enq_rdy  output  1  queue can accept
- enq_waddr  input  5  destination register
- enq_wdata  input  32  write data
- drain_en  input  1  regfile write port available this cycle
- wen  output  1  regfile write enable
- waddr  output  5  regfile write address
- wdata  output  32  regfile write data
- lk_addr0  input  5  lookup address, port 0
- lk_hit0  output  1  pending write to lk_addr0 exists
- lk_data0  output  32  newest pending data for lk_addr0
- lk_addr1  input  5  lookup address, port 1
- lk_hit1  output  1  pending write to lk_addr1 exists
- lk_data1  output  32  newest pending data for lk_addr1
- count  output  $clog2(DEPTH)+1  occupancy

Function
REQ-004 The block SHALL be an in-order FIFO of {waddr, wdata} entries feeding a 32x32 regfile write port.
REQ-005 enq_rdy SHALL equal (count < DEPTH); it SHALL NOT depend on drain_en in the same cycle.
REQ-006 A transfer SHALL occur on a rising edge where enq_val && enq_rdy.
REQ-007 A transfer with enq_waddr == 0 SHALL be accepted and discarded; it SHALL leave count unchanged and SHALL never reach wen.
REQ-008 wen SHALL equal drain_en && (count != 0); waddr/wdata SHALL show the head entry combinationally; when wen is 0, waddr and wdata SHALL be 0.
REQ-009 The head SHALL be popped on every rising edge where wen is 1.
REQ-010 Simultaneous enqueue and pop SHALL leave count unchanged, including at count == DEPTH-1 and count == 1.
REQ-011 An entry enqueued at edge N SHALL appear on wen no earlier than cycle N+1; there SHALL be no same-cycle pass-through.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH.
REQ-013 Lookup SHALL be combinational over registered entries only. lk_hitK SHALL be 1 iff lk_addrK != 0 and some valid entry matches. lk_dataK SHALL be the data of the youngest matching entry, else 0.
REQ-014 The head entry SHALL remain visible to lookup during the cycle it drives wen.
REQ-015 An in-flight enq_* transfer in the same cycle SHALL NOT be visible to lookup.

Reset
REQ-016 Asserting reset SHALL immediately clear count and both pointers and invalidate all entries.
REQ-017 During reset, enq_rdy SHALL be 1, and wen, waddr, wdata, lk_hit*, and lk_data* SHALL be 0.
REQ-018 Reset mid-operation SHALL discard pending writes; no wen SHALL occur for them after reset is released.
REQ-019 Entry data storage need not be reset; only valid state SHALL be reset.

Configuration
REQ-020 Macro REGFILE_WBQ_FWD_EN SHALL control lookup.
- Defined: lookup SHALL behave per REQ-013..REQ-015.
- Undefined: lk_hit0/1 SHALL be tied to 0, lk_data0/1 SHALL be tied to 0, and no match logic SHALL be synthesized. All other behaviour SHALL be identical.

Structure
REQ-021 Package regfile_wbq_pkg SHALL hold typedef wbq_entry_t {logic [4:0] addr; logic [31:0] data;}, constant RF_ADDR_W = 5, and constant RF_DATA_W = 32.
REQ-022 Youngest-match priority SHALL be one sub-module, regfile_wbq_match, instantiated once per lookup port, present only with REGFILE_WBQ_FWD_EN.

Verification
REQ-023 Fill and drain: DEPTH=4, drain_en=0, enqueue (1,0x11), (2,0x22), (3,0x33), (4,0x44).
- count SHALL reach 4 and enq_rdy SHALL be 0.
- After raising drain_en, wen SHALL be 1 for 4 cycles with waddr 1,2,3,4 in order.
- count SHALL then be 0.
REQ-024 Zero register: enqueue (0,0xDEAD).
- count SHALL stay 0, wen SHALL never assert, and lk_addr0=0 SHALL give hit0=0.
REQ-025 Forwarding (FWD_EN defined): enqueue (5,0xA) then (5,0xB) with drain_en=0.
- lk_addr0=5 SHALL give hit0=1, data0=0xB.
- After one drain, data0 SHALL still be 0xB.
- After two drains, hit0 SHALL be 0.
REQ-026 Full with simultaneous enqueue and drain: count=4, drain_en=1, enq_val=1.
- enq_rdy SHALL be 0, count SHALL become 3, and the offered entry SHALL NOT be accepted.
- On the next edge, the transfer SHALL occur and count SHALL stay 3.
REQ-027 Reset mid-operation: count=3, assert reset asynchronously between edges.
- count SHALL become 0 and wen SHALL become 0 immediately.
- After release, no stale write SHALL appear on wen.
REQ-028 FWD_EN undefined: repeat REQ-025 stimulus.
- hit0 SHALL be 0 and data0 SHALL be 0 throughout.
- The drain order SHALL be unchanged.
